// File: rtl/cdb_buffered.sv
// Buffered common data bus with per-FU collapsing result buffers and rotating round-robin grant onto N lanes.
// Optional macro CDB_PERF_CNT_EN adds saturating stall/grant/squash counters.

package cdb_pkg;
    typedef logic [3:0] br_mask_t;
    typedef enum logic [1:0] {NOTHING = 2'd0, CLEAR = 2'd1, SQUASH = 2'd2} br_task_t;

    typedef struct packed { logic [4:0] dest_reg_idx; logic valid; } dec_vals_t;
    typedef struct packed { logic [5:0] reg_idx; } phys_tag_t;
    typedef struct packed { dec_vals_t decoded_vals; phys_tag_t t; } decoded_t;

    typedef struct packed {
        decoded_t    decoded_vals;
        logic [31:0] result;
        br_mask_t    b_mask;
        br_mask_t    b_id;
    } fu_packet_t;

    typedef struct packed {
        logic [4:0]  reg_idx;
        logic [5:0]  p_reg_idx;
        logic [31:0] reg_val;
        logic        valid;
        logic        taken;
        br_mask_t    b_mask;
    } cdb_packet_t;

    function automatic logic br_kill(fu_packet_t p, br_task_t tsk, br_mask_t id);
        return (tsk == SQUASH) && ((p.b_mask & id) != 4'b0000) && (p.b_id != id);
    endfunction

    function automatic fu_packet_t br_clear(fu_packet_t p, br_task_t tsk, br_mask_t id);
        fu_packet_t r;
        r = p;
        r.b_mask = (tsk == CLEAR) ? (p.b_mask & ~id) : p.b_mask;
        return r;
    endfunction

    function automatic cdb_packet_t to_cdb(fu_packet_t p);
        cdb_packet_t c;
        c.reg_idx   = p.decoded_vals.decoded_vals.dest_reg_idx;
        c.p_reg_idx = p.decoded_vals.t.reg_idx;
        c.reg_val   = p.result;
        c.valid     = p.decoded_vals.decoded_vals.valid;
        c.taken     = 1'b0;
        c.b_mask    = p.b_mask;
        return c;
    endfunction
endpackage

module cdb_buffered_chk #(
    parameter int NUM_FU = 4
) (
    input logic              clock,
    input logic              reset,
    input logic [NUM_FU-1:0] fu_done,
    input logic [NUM_FU-1:0] stall_sig
);
    // A stalled FU presenting a result loses it; flag the protocol breach.
    assert property (@(posedge clock) disable iff (reset) ((fu_done & stall_sig) == {NUM_FU{1'b0}}))
        else $error("cdb_buffered: fu_done=%b while stall_sig=%b", fu_done, stall_sig);
endmodule

module cdb_buffered
    import cdb_pkg::*;
#(
    parameter int N         = 2,
    parameter int NUM_FU    = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_FU-1:0] fu_done,
    input  fu_packet_t        wr_data [NUM_FU],
    input  logic              taken,
    input  br_task_t          rem_br_task,
    input  br_mask_t          rem_b_id,
    output cdb_packet_t       entries [N],
    output logic [NUM_FU-1:0] stall_sig
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_grants,
    output logic [31:0]       perf_squashed
`endif
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    fu_packet_t        rbuf_q [NUM_FU][BUF_DEPTH];
    fu_packet_t        rbuf_d [NUM_FU][BUF_DEPTH];
    logic [CNT_W-1:0]  count_q [NUM_FU];
    logic [CNT_W-1:0]  count_d [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    cdb_packet_t       entries_q [N];
    cdb_packet_t       entries_d [N];
    logic [NUM_FU-1:0] stall_q, stall_d;

    fu_packet_t                       cand_s [NUM_FU];
    logic [NUM_FU-1:0]                elig_s, grant_s, accept_s, kill_in_s;
    logic [NUM_FU-1:0][BUF_DEPTH-1:0] kill_buf_s;
    int                               lane_of_s [NUM_FU];

    // Branch filtering and per-FU candidate: buffer head if any, otherwise the bypassed input.
    always_comb begin
        kill_buf_s = '0;
        kill_in_s  = '0;
        accept_s   = '0;
        elig_s     = '0;
        cand_s     = '{default: '0};
        for (int j = 0; j < NUM_FU; j++) begin
            accept_s[j]  = fu_done[j] && !stall_q[j];
            kill_in_s[j] = accept_s[j] && br_kill(wr_data[j], rem_br_task, rem_b_id);
            for (int i = 0; i < BUF_DEPTH; i++) begin
                kill_buf_s[j][i] = (i < int'(count_q[j])) && br_kill(rbuf_q[j][i], rem_br_task, rem_b_id);
            end
            if (count_q[j] != {CNT_W{1'b0}}) begin
                cand_s[j] = br_clear(rbuf_q[j][0], rem_br_task, rem_b_id);
                elig_s[j] = !kill_buf_s[j][0];
            end else begin
                cand_s[j] = br_clear(wr_data[j], rem_br_task, rem_b_id);
                elig_s[j] = accept_s[j] && !kill_in_s[j];
            end
        end
    end

    // Round-robin scan from rr_ptr; the k-th eligible FU in scan order takes lane k.
    always_comb begin
        int               n_grant;
        logic             hit;
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] last;
        grant_s   = '0;
        lane_of_s = '{default: 0};
        n_grant   = 0;
        hit       = 1'b0;
        idx       = '0;
        last      = rr_ptr_q;
        for (int o = 0; o < NUM_FU; o++) begin
            idx            = PTR_W'((int'(rr_ptr_q) + o) % NUM_FU);
            hit            = elig_s[idx] && (n_grant < N);
            grant_s[idx]   = hit;
            lane_of_s[idx] = n_grant;
            last           = hit ? idx : last;
            n_grant        = n_grant + (hit ? 32'sd1 : 32'sd0);
        end
        rr_ptr_d = (n_grant != 0) ? PTR_W'((int'(last) + 1) % NUM_FU) : rr_ptr_q;
    end

    // Lane mux; ungranted lanes stay zero, lane 0 always carries the branch outcome.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            entries_d[k] = '0;
            for (int j = 0; j < NUM_FU; j++) begin
                entries_d[k] = (grant_s[j] && (lane_of_s[j] == k)) ? to_cdb(cand_s[j]) : entries_d[k];
            end
        end
        entries_d[0].taken = taken;
    end

    // Buffer next state: drop popped/squashed entries, compact survivors, append the unbypassed input.
    always_comb begin
        int   wr;
        logic keep;
        logic app;
        rbuf_d  = '{default: '0};
        count_d = '{default: '0};
        stall_d = '0;
        wr      = 0;
        keep    = 1'b0;
        app     = 1'b0;
        for (int j = 0; j < NUM_FU; j++) begin
            wr = 0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                keep = (i < int'(count_q[j])) && !kill_buf_s[j][i] && !((i == 0) && grant_s[j]);
                for (int s = 0; s < BUF_DEPTH; s++) begin
                    rbuf_d[j][s] = (keep && (s == wr)) ? br_clear(rbuf_q[j][i], rem_br_task, rem_b_id)
                                                       : rbuf_d[j][s];
                end
                wr = wr + (keep ? 32'sd1 : 32'sd0);
            end
            app = accept_s[j] && !kill_in_s[j] && !((count_q[j] == {CNT_W{1'b0}}) && grant_s[j]);
            for (int s = 0; s < BUF_DEPTH; s++) begin
                rbuf_d[j][s] = (app && (s == wr)) ? br_clear(wr_data[j], rem_br_task, rem_b_id)
                                                  : rbuf_d[j][s];
            end
            wr         = wr + (app ? 32'sd1 : 32'sd0);
            count_d[j] = CNT_W'(wr);
            stall_d[j] = (count_d[j] == CNT_W'(BUF_DEPTH));
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rbuf_q    <= '{default: '0};
            count_q   <= '{default: '0};
            rr_ptr_q  <= '0;
            entries_q <= '{default: '0};
            stall_q   <= '0;
        end else begin
            rbuf_q    <= rbuf_d;
            count_q   <= count_d;
            rr_ptr_q  <= rr_ptr_d;
            entries_q <= entries_d;
            stall_q   <= stall_d;
        end
    end

    assign entries   = entries_q;
    assign stall_sig = stall_q;

    cdb_buffered_chk #(.NUM_FU(NUM_FU)) u_chk (
        .clock     (clock),
        .reset     (reset),
        .fu_done   (fu_done),
        .stall_sig (stall_q)
    );

`ifdef CDB_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_grant_q, perf_grant_d;
    logic [31:0] perf_sq_q, perf_sq_d;
    logic [31:0] n_sq_s;

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Saturating counter next state.
    always_comb begin
        n_sq_s = 32'd0;
        for (int j = 0; j < NUM_FU; j++) begin
            n_sq_s = n_sq_s + 32'($countones(kill_buf_s[j])) + (kill_in_s[j] ? 32'd1 : 32'd0);
        end
        perf_stall_d = sat_add(perf_stall_q, {31'd0, |stall_q});
        perf_grant_d = sat_add(perf_grant_q, 32'($countones(grant_s)));
        perf_sq_d    = sat_add(perf_sq_q, n_sq_s);
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_q <= 32'd0;
            perf_grant_q <= 32'd0;
            perf_sq_q    <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_grant_q <= perf_grant_d;
            perf_sq_q    <= perf_sq_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_grants       = perf_grant_q;
    assign perf_squashed     = perf_sq_q;
`endif
endmodule

// File: tb/tb_cdb_buffered.sv
// Randomized bench for cdb_buffered: per-FU result queues and a round-robin scan model predict every lane.
module tb_cdb_buffered;
    import cdb_pkg::*;

    localparam int N         = 2;
    localparam int NUM_FU    = 4;
    localparam int BUF_DEPTH = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_FU-1:0] fu_done = '0;
    fu_packet_t        wr_data [NUM_FU];
    logic              taken = 1'b0;
    br_task_t          rem_br_task = NOTHING;
    br_mask_t          rem_b_id = 4'b0000;
    cdb_packet_t       entries [N];
    logic [NUM_FU-1:0] stall_sig;
`ifdef CDB_PERF_CNT_EN
    logic [31:0]       perf_stall_cycles, perf_grants, perf_squashed;
`endif

    always #5 clock = ~clock;

    cdb_buffered #(.N(N), .NUM_FU(NUM_FU), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .fu_done     (fu_done),
        .wr_data     (wr_data),
        .taken       (taken),
        .rem_br_task (rem_br_task),
        .rem_b_id    (rem_b_id),
        .entries     (entries),
        .stall_sig   (stall_sig)
`ifdef CDB_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_grants       (perf_grants),
        .perf_squashed     (perf_squashed)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Reference state: one FIFO of pending results per FU plus the scan start.
    fu_packet_t        mq [NUM_FU][$];
    int                m_rr = 0;
    cdb_packet_t       exp_lane [N];
    logic [NUM_FU-1:0] exp_stall = '0;
    longint            m_stall_cyc = 0, m_grants = 0, m_sq = 0;
    fu_packet_t        stim [NUM_FU];

    function automatic bit is_squashed(fu_packet_t p);
        return rem_br_task == SQUASH && (p.b_mask & rem_b_id) != 4'b0000 && p.b_id != rem_b_id;
    endfunction

    function automatic fu_packet_t after_clear(fu_packet_t p);
        fu_packet_t r = p;
        if (rem_br_task == CLEAR) r.b_mask = p.b_mask & ~rem_b_id;
        return r;
    endfunction

    function automatic cdb_packet_t broadcast(fu_packet_t p);
        cdb_packet_t c = '0;
        c.reg_idx   = p.decoded_vals.decoded_vals.dest_reg_idx;
        c.p_reg_idx = p.decoded_vals.t.reg_idx;
        c.reg_val   = p.result;
        c.valid     = p.decoded_vals.decoded_vals.valid;
        c.b_mask    = p.b_mask;
        return c;
    endfunction

    task automatic model_edge();
        fu_packet_t cand [NUM_FU];
        bit         has [NUM_FU];
        bit         from_q [NUM_FU];
        bit         won [NUM_FU];
        int         g = 0, last = 0, j;
        for (int k = 0; k < N; k++) exp_lane[k] = '0;
        if (reset) begin
            for (int f = 0; f < NUM_FU; f++) mq[f].delete();
            m_rr = 0; exp_stall = '0; m_stall_cyc = 0; m_grants = 0; m_sq = 0;
            return;
        end
        if (exp_stall != '0) m_stall_cyc++;
        for (int f = 0; f < NUM_FU; f++) begin
            has[f] = 0; from_q[f] = 0; won[f] = 0; cand[f] = '0;
            if (mq[f].size() > 0) begin
                cand[f] = mq[f][0]; has[f] = !is_squashed(cand[f]); from_q[f] = 1;
            end else if (fu_done[f]) begin
                cand[f] = stim[f]; has[f] = !is_squashed(cand[f]);
            end
        end
        for (int o = 0; o < NUM_FU; o++) begin
            j = (m_rr + o) % NUM_FU;
            if (has[j] && g < N) begin
                won[j] = 1; exp_lane[g] = broadcast(after_clear(cand[j])); g++; last = j;
            end
        end
        if (g > 0) m_rr = (last + 1) % NUM_FU;
        exp_lane[0].taken = taken;
        m_grants += g;
        for (int f = 0; f < NUM_FU; f++) begin
            fu_packet_t nq [$];
            if (won[f] && from_q[f]) void'(mq[f].pop_front());
            for (int i = 0; i < mq[f].size(); i++) begin
                if (is_squashed(mq[f][i])) m_sq++;
                else nq.push_back(after_clear(mq[f][i]));
            end
            if (fu_done[f]) begin
                if (is_squashed(stim[f])) m_sq++;
                else if (!(won[f] && !from_q[f])) nq.push_back(after_clear(stim[f]));
            end
            mq[f] = nq;
            exp_stall[f] = (mq[f].size() == BUF_DEPTH);
        end
    endtask

    task automatic rand_stim();
        for (int f = 0; f < NUM_FU; f++) begin
            stim[f].decoded_vals.decoded_vals.dest_reg_idx = 5'($urandom);
            stim[f].decoded_vals.decoded_vals.valid        = ($urandom_range(0, 7) != 0);
            stim[f].decoded_vals.t.reg_idx                 = 6'($urandom);
            stim[f].result                                 = $urandom;
            stim[f].b_mask                                 = 4'($urandom);
            stim[f].b_id                                   = 4'b0001 << $urandom_range(0, 3);
        end
    endtask

    task automatic step(input logic rst, input logic [NUM_FU-1:0] want, input br_task_t tsk, input br_mask_t id);
        @(negedge clock);
        reset       = rst;
        fu_done     = want & ~exp_stall;
        rem_br_task = tsk;
        rem_b_id    = id;
        taken       = 1'($urandom);
        for (int f = 0; f < NUM_FU; f++) wr_data[f] = stim[f];
        model_edge();
        @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) check_eq($sformatf("lane%0d", k), 64'(entries[k]), 64'(exp_lane[k]));
        check_eq("stall_sig", 64'(stall_sig), 64'(exp_stall));
`ifdef CDB_PERF_CNT_EN
        check_eq("perf_stall", 64'(perf_stall_cycles), 64'(m_stall_cyc));
        check_eq("perf_grants", 64'(perf_grants), 64'(m_grants));
        check_eq("perf_squashed", 64'(perf_squashed), 64'(m_sq));
`endif
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rand_stim();
            step(1'b0, '0, NOTHING, 4'b0000);
        end
    endtask

    initial begin
        br_task_t tsk;
        int       r;
        rand_stim();
        for (int f = 0; f < NUM_FU; f++) wr_data[f] = stim[f];
        step(1'b1, '0, NOTHING, 4'b0000);
        step(1'b1, '0, NOTHING, 4'b0000);
        // Single bypass winner, then all four FUs contending.
        rand_stim(); step(1'b0, 4'b0001, NOTHING, 4'b0000);
        idle(2);
        rand_stim(); step(1'b0, 4'b1111, NOTHING, 4'b0000);
        idle(3);
        // Queue a squashable and a safe entry behind FU2, then squash.
        rand_stim(); stim[2].b_mask = 4'b0100; stim[2].b_id = 4'b0001; step(1'b0, 4'b1111, NOTHING, 4'b0000);
        rand_stim(); stim[2].b_mask = 4'b0000; step(1'b0, 4'b1111, NOTHING, 4'b0000);
        rand_stim(); step(1'b0, 4'b0000, SQUASH, 4'b0100);
        idle(4);
        // Buffered entries with mask 0110, then clear bit 1.
        rand_stim(); for (int f = 0; f < NUM_FU; f++) stim[f].b_mask = 4'b0110; step(1'b0, 4'b1111, NOTHING, 4'b0000);
        rand_stim(); for (int f = 0; f < NUM_FU; f++) stim[f].b_mask = 4'b0110; step(1'b0, 4'b1111, NOTHING, 4'b0000);
        rand_stim(); step(1'b0, 4'b0000, CLEAR, 4'b0010);
        idle(4);
        // Fill buffers, then reset mid-traffic.
        for (int c = 0; c < 3; c++) begin
            rand_stim(); step(1'b0, 4'b1111, NOTHING, 4'b0000);
        end
        step(1'b1, 4'b1111, NOTHING, 4'b0000);
        idle(2);
        for (int c = 0; c < 3000; c++) begin
            rand_stim();
            r = $urandom_range(0, 9);
            tsk = (r < 6) ? NOTHING : (r < 8) ? CLEAR : SQUASH;
            step(($urandom_range(0, 199) == 0), 4'($urandom | $urandom), tsk, 4'b0001 << $urandom_range(0, 3));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cdb_buffered.md
Name: cdb_buffered

Overview:
- Next-generation common data bus.
- Arbitrates up to N completed FU results per cycle onto N registered CDB lanes.
- Adds a per-FU collapsing result buffer of BUF_DEPTH entries, so losing FUs are not stalled immediately.
- Uses a rotating round-robin priority instead of fixed priority, and applies branch SQUASH/CLEAR to buffered results as well as in-flight ones.
- Sits between FU writeback and RS/ROB/map-table wakeup.

Parameters:
N, `N, number of CDB lanes (grants per cycle)
NUM_FU, `NUM_FUS_CDB, number of requesting FUs
BUF_DEPTH, 2, result buffer entries per FU (>=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
fu_done  input  NUM_FU  FU j presents a valid result this cycle
wr_data  input  NUM_FU x FU_PACKET  result packets, indexed by FU
taken  input  1  branch outcome, forwarded on lane 0
rem_br_task  input  BR_TASK  NOTHING / CLEAR / SQUASH for the resolving branch
rem_b_id  input  BR_MASK  one-hot id of the resolving branch
entries  output  N x CDB_PACKET  registered broadcast lanes
stall_sig  output  NUM_FU  FU j must not assert fu_done next cycle

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset state:
  - entries = '0
  - all buffers empty (count = 0)
  - rr_ptr = 0
  - stall_sig = 0
- Candidate per FU j:
  - Buffer j non-empty: candidate is the buffer head (oldest).
  - Buffer j empty and fu_done[j]: candidate is wr_data[j] (same-cycle bypass).
- Branch filtering, applied to every candidate, every buffered entry and every incoming packet before arbitration and storage:
  - SQUASH: discard any packet with (b_mask & rem_b_id) != 0 and b_id != rem_b_id.
  - CLEAR: b_mask &= ~rem_b_id.
  - NOTHING: unchanged.
  - A squashed candidate is not eligible for a grant.
- Arbitration: scan FU indices starting at rr_ptr, wrapping modulo NUM_FU. Grant the first N eligible candidates. Lane k carries the k-th grant in scan order.
- rr_ptr update:
  - At least one grant: rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
  - No grants: rr_ptr unchanged.
- Buffer update, per FU, same edge:
  - A granted head is popped; the remaining entries shift toward the head, preserving order.
  - After squash, surviving entries compact toward the head, preserving order.
  - An incoming packet (fu_done[j] and not squashed) that was not granted via bypass is appended at the tail.
  - Pop, squash and append may all occur in one cycle; resulting count = old - popped - squashed + appended.
- Output lanes:
  - next_entries[k] fields: reg_idx = decoded_vals.decoded_vals.dest_reg_idx, p_reg_idx = decoded_vals.t.reg_idx, reg_val = result, valid = decoded_vals.decoded_vals.valid.
  - Ungranted lanes are '0.
  - next_entries[0].taken = taken.
  - entries <= next_entries each cycle.
- Latency:
  - Bypass win: 1 cycle (fu_done at edge t, visible on entries after edge t+1).
  - Buffered results: +1 cycle per cycle spent waiting.
- stall_sig[j] = (count[j] == BUF_DEPTH), taken from the registered count (no combinational path from fu_done).
- Protocol violation: fu_done[j] while stall_sig[j] = 1 is a violation. The packet is dropped and buffer contents are unchanged; an assertion fires under simulation.
- Ordering: results from one FU broadcast in arrival order. No ordering guarantee across FUs.
- Reset asserted mid-operation: all buffered results are discarded; the next cycle's entries are '0.

Optional Feature:
- Macro: CDB_PERF_CNT_EN.
- When defined, adds output ports:
  - perf_stall_cycles [31:0]: increments each cycle any stall_sig bit is 1.
  - perf_grants [31:0]: adds the number of grants each cycle.
  - perf_squashed [31:0]: adds the number of buffered or incoming packets discarded by SQUASH.
  - All counters reset to 0, saturate at all-ones, and never affect datapath behaviour.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Bypass: N=2, NUM_FU=4, fu_done=4'b0001, reset released, idle -> next cycle entries[0].valid=1 with FU0's p_reg_idx; entries[1]='0; buffers stay empty.
2. Contention and buffering: N=1, fu_done=4'b1111 for one cycle, rr_ptr=0 -> broadcasts appear FU0, FU1, FU2, FU3 on consecutive cycles; stall_sig=0 throughout with BUF_DEPTH=2.
3. Full buffer: N=1, BUF_DEPTH=2, FU1 loses three times while FU0 is held continuously asserted -> stall_sig[1]=1 once count[1]=2. A fu_done[1] while stalled is dropped and the assertion fires; fairness still grants FU1 within NUM_FU cycles.
4. Squash: FU2 buffer holds entries with b_mask=4'b0100 and 4'b0000; rem_br_task=SQUASH, rem_b_id=4'b0100 -> first entry removed, second compacts to head, count[2]=1, and it appears on the CDB next.
5. Clear: buffered entry with b_mask=4'b0110, CLEAR with rem_b_id=4'b0010 -> the later broadcast carries b_mask=4'b0100; nothing is discarded.
6. Reset mid-traffic: buffers partially full; reset=1 for one cycle -> entries='0, stall_sig=0, and with CDB_PERF_CNT_EN all counters read 0.
